// File: rtl/tsal_pkg.sv
// ----------------------------------------------------------------------------
// tsal_pkg
// Shared definitions for the TSAL ADC SPI reader:
//   - tsal_state_e : reader FSM state encoding (also driven out on the debug port)
//   - TSAL_*_BITS  : default ADC081S021-style frame layout
//   - tsal_cnt_w() : counter width helper that never returns zero
// Optional feature macro used by the reader: TSAL_ADC_AVERAGE_EN.
// ----------------------------------------------------------------------------
package tsal_pkg;

  localparam int TSAL_FRAME_BITS = 16;  // s_clk rising edges per frame
  localparam int TSAL_LEAD_BITS  = 3;   // leading zeros preceding the data
  localparam int TSAL_DATA_BITS  = 8;   // data bits, MSB first

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } tsal_state_e;

  // Width able to hold 0..n-1, at least one bit so that n=1 still elaborates.
  function automatic int tsal_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tsal_sclk_gen.sv
// ----------------------------------------------------------------------------
// tsal_sclk_gen
// Half-period tick counter. Once loaded it counts clk cycles and pulses o_tick
// on the last cycle of every CLK_DIV-cycle window, wrapping automatically so
// consecutive half-periods follow back to back. Clear stops it at zero.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  synchronous active-low reset
//   i_load   restart the window at zero and start running
//   i_clear  stop and hold at zero (wins over i_load)
//   o_tick   high during the final cycle of each window while running
// ----------------------------------------------------------------------------
module tsal_sclk_gen
  import tsal_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_clear,
  output logic o_tick
);

  localparam int            CW   = tsal_cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_run;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = r_run && (r_cnt == LAST);

endmodule

// File: rtl/tsal_adc_spi_reader.sv
// ----------------------------------------------------------------------------
// tsal_adc_spi_reader
// SPI master for a single-channel 8-bit ADC (3 leading zeros, 8 data bits
// MSB first, 5 ignored trailing bits). Runs back-to-back conversions while
// i_enable is high and hands each good sample to the threshold comparator.
//
// Optional feature: define TSAL_ADC_AVERAGE_EN to output a 4-sample moving
// average of good frames instead of the raw captured value.
//
// Ports:
//   i_clk            system clock
//   i_rst_n          synchronous active-low reset
//   i_enable         run continuous conversions while high
//   i_s_data         ADC serial data (MISO)
//   o_s_clk          SPI clock, idles high (CPOL=1)
//   o_cs             ADC chip select, active low
//   o_sample         last good sample (or moving average)
//   o_sample_valid   one-cycle strobe when o_sample updates
//   o_frame_err      one-cycle strobe: a leading bit read 1
//   o_dbg_state      current FSM state (tsal_state_e encoding)
//
// Output strobe semantics: o_sample_valid and o_frame_err are single-cycle,
// mutually exclusive pulses issued in the cycle cs returns high. There is no
// back-pressure; o_sample is stable from a valid strobe until the next one.
// ----------------------------------------------------------------------------
module tsal_adc_spi_reader
  import tsal_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = TSAL_FRAME_BITS,
  parameter int LEAD_BITS  = TSAL_LEAD_BITS,
  parameter int DATA_BITS  = TSAL_DATA_BITS,
  parameter int GAP_CYCLES = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_s_data,
  output logic                 o_s_clk,
  output logic                 o_cs,
  output logic [DATA_BITS-1:0] o_sample,
  output logic                 o_sample_valid,
  output logic                 o_frame_err,
  output logic [2:0]           o_dbg_state
);

  localparam int            BW       = tsal_cnt_w(FRAME_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] LEAD_END = BW'(LEAD_BITS);
  localparam logic [BW-1:0] DATA_END = BW'(LEAD_BITS + DATA_BITS);
  localparam int            GW       = tsal_cnt_w(GAP_CYCLES);
  localparam int            GAP_N    = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_N);
  // With a single gap cycle DONE itself is the whole gap.
  localparam logic          NO_GAP   = (GAP_CYCLES <= 1);

  tsal_state_e          r_state;
  logic                 r_cs;
  logic                 r_sclk;
  logic [BW-1:0]        r_bit;
  logic                 r_phase;     // 0: low half of the bit, 1: high half
  logic                 r_lead_err;  // sticky for the current frame
  logic [GW-1:0]        r_gap;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] r_sample;
  logic                 r_valid;
  logic                 r_ferr;

  logic                 w_tick;
  logic                 w_gap_end;
  logic                 w_load;
  logic                 w_last_tick;
  logic [DATA_BITS-1:0] w_sample_next;

  assign w_gap_end   = ((r_state == ST_GAP) && (r_gap == GAP_LAST)) ||
                       ((r_state == ST_DONE) && NO_GAP);
  // enable is only looked at in IDLE and at the end of the gap.
  assign w_load      = ((r_state == ST_IDLE) || w_gap_end) && i_enable;
  assign w_last_tick = (r_state == ST_SHIFT) && w_tick && r_phase &&
                       (r_bit == LAST_BIT);

  tsal_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_clear (w_last_tick),
    .o_tick  (w_tick)
  );

`ifdef TSAL_ADC_AVERAGE_EN
  logic [DATA_BITS-1:0] r_win [4];
  logic [DATA_BITS+1:0] r_sum;
  logic                 r_primed;
  logic [DATA_BITS+1:0] w_sum_next;

  // Running sum: drop the oldest slot, add the new value. The very first good
  // frame fills all four slots, so the sum starts at four times that value.
  always_comb begin
    w_sum_next = {r_data, 2'b00};
    if (r_primed) begin
      w_sum_next = r_sum - {2'b00, r_win[3]} + {2'b00, r_data};
    end
  end

  assign w_sample_next = w_sum_next[DATA_BITS+1:2];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) r_win[i] <= '0;
      r_sum    <= '0;
      r_primed <= 1'b0;
    end else if (w_last_tick && !r_lead_err) begin
      r_sum    <= w_sum_next;
      r_primed <= 1'b1;
      if (!r_primed) begin
        for (int i = 0; i < 4; i++) r_win[i] <= r_data;
      end else begin
        r_win[0] <= r_data;
        for (int i = 1; i < 4; i++) r_win[i] <= r_win[i-1];
      end
    end
  end
`else
  assign w_sample_next = r_data;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cs       <= 1'b1;
      r_sclk     <= 1'b1;
      r_bit      <= '0;
      r_phase    <= 1'b0;
      r_lead_err <= 1'b0;
      r_gap      <= '0;
      r_data     <= '0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (w_load) begin
        r_state    <= ST_SETUP;
        r_cs       <= 1'b0;
        r_sclk     <= 1'b1;
        r_bit      <= '0;
        r_phase    <= 1'b0;
        r_lead_err <= 1'b0;
      end else begin
        case (r_state)
          ST_SETUP: begin
            if (w_tick) begin
              r_state <= ST_SHIFT;
              r_sclk  <= 1'b0;
            end
          end
          ST_SHIFT: begin
            if (w_tick) begin
              if (!r_phase) begin
                // This edge drives s_clk 0->1: capture the bit now.
                r_sclk  <= 1'b1;
                r_phase <= 1'b1;
                if (r_bit < LEAD_END) begin
                  if (i_s_data) r_lead_err <= 1'b1;
                end else if (r_bit < DATA_END) begin
                  r_data <= {r_data[DATA_BITS-2:0], i_s_data};
                end
              end else if (r_bit == LAST_BIT) begin
                r_state <= ST_DONE;
                r_cs    <= 1'b1;
                if (r_lead_err) begin
                  r_ferr <= 1'b1;
                end else begin
                  r_valid  <= 1'b1;
                  r_sample <= w_sample_next;
                end
              end else begin
                r_bit   <= r_bit + 1'b1;
                r_phase <= 1'b0;
                r_sclk  <= 1'b0;
              end
            end
          end
          ST_DONE, ST_GAP: begin
            if (w_gap_end) begin
              r_state <= ST_IDLE;
            end else if (r_state == ST_DONE) begin
              r_state <= ST_GAP;
              r_gap   <= '0;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_s_clk        = r_sclk;
  assign o_cs           = r_cs;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_valid;
  assign o_frame_err    = r_ferr;
  assign o_dbg_state    = r_state;

endmodule
